// File: rtl/seq_detect_param_if.sv
// Port bundle for the parametrised serial-pattern detector.
// Both ends must use the same PAT_W and CNT_W as the detector they connect to.
interface seq_detect_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  // en qualifies inp for one cycle; there is no ready, so the detector always accepts a valid bit.
  logic             en;
  logic             inp;
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic             clr_cnt;
  logic             outp;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en, inp, load, pat_in, clr_cnt,
    input  outp, pattern, match_cnt, cnt_sat
  );

  modport slave (
    input  en, inp, load, pat_in, clr_cnt,
    output outp, pattern, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detect_param.sv
// Mealy serial-pattern detector with a reloadable pattern, selectable overlap mode
// and a saturating match counter with a sticky saturation flag.
module seq_detect_param #(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] RST_PATTERN = 4'b1011,
  parameter bit               OVERLAP     = 1'b1,
  parameter int               CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_param_if.slave bus
);
  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  pattern;
  logic [CNT_W-1:0]  match_cnt;
  logic              cnt_sat;
  logic              match;

  // The incoming bit completes the window, so a match is flagged in the same cycle.
  assign match = !rst && bus.en && !bus.load && (fill == FILL_MAX)
                 && ({hist, bus.inp} == pattern);

  assign bus.outp      = match;
  assign bus.pattern   = pattern;
  assign bus.match_cnt = match_cnt;
  assign bus.cnt_sat   = cnt_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pattern   <= RST_PATTERN;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      if (bus.load) begin
        pattern <= bus.pat_in;
        hist    <= '0;
        fill    <= '0;
      end else if (bus.en) begin
        hist <= {hist[PAT_W-3:0], bus.inp};
        if (match && !OVERLAP) begin
          fill <= '0;
        end else if (fill != FILL_MAX) begin
          fill <= fill + FILL_W'(1);
        end
      end

      // The counter sees every edge, including load cycles (where match is already 0).
      if (bus.clr_cnt) begin
        match_cnt <= {{(CNT_W-1){1'b0}}, match};
        cnt_sat   <= 1'b0;
      end else if (match) begin
        if (match_cnt != '1) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end else begin
          cnt_sat <= 1'b1;
        end
      end
    end
  end
endmodule
